// File: rtl/traffic_light_ctrl_param_if.sv
// Signal bundle between the traffic-light controller and its environment.
// All signals are plain levels with no valid/ready handshake. The sensor and
// request inputs may change at any time because the controller synchronises
// them. The lamp, state and tick outputs are registered-state decodes and are
// valid in every cycle.
interface traffic_light_ctrl_param_if;
    logic       i_Vs;
    logic       i_ped_req;
    logic       o_Main_red;
    logic       o_Main_yellow;
    logic       o_Main_green;
    logic       o_Side_red;
    logic       o_Side_yellow;
    logic       o_Side_green;
    logic       o_walk;
    logic [2:0] o_state;
    logic       o_tick;

    // The environment (sensors, request button, lamp observer) uses this side.
    modport master (
        output i_Vs, i_ped_req,
        input  o_Main_red, o_Main_yellow, o_Main_green,
        input  o_Side_red, o_Side_yellow, o_Side_green,
        input  o_walk, o_state, o_tick
    );

    // The controller uses this side.
    modport slave (
        input  i_Vs, i_ped_req,
        output o_Main_red, o_Main_yellow, o_Main_green,
        output o_Side_red, o_Side_yellow, o_Side_green,
        output o_walk, o_state, o_tick
    );
endinterface

// File: rtl/traffic_light_ctrl_param.sv
// Main-road / side-road traffic-light controller with a pedestrian phase.
// A prescaler produces a one-cycle tick. The state machine and its dwell timer
// advance only on ticks. The main road stays green until a side-road vehicle
// or a pedestrian request is present.
module traffic_light_ctrl_param #(
    parameter int TICK_DIV     = 50,
    parameter int TW           = 8,
    parameter int LONG_TICKS   = 20,
    parameter int SHORT_TICKS  = 4,
    parameter int ALLRED_TICKS = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    traffic_light_ctrl_param_if.slave    bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] DIV_LAST    = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0] SHORT_LAST  = TW'(SHORT_TICKS - 1);
    localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_TICKS - 1);
    localparam logic [TW-1:0] TIMER_MAX   = '1;

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [PW-1:0]   div_cnt;
    logic            tick;
    logic            advance;
    logic            vs_meta;
    logic            vs_s;
    logic            ped_meta;
    logic            ped_s;
    logic            ped_pending;

    // Two-flop synchronisers for the asynchronous sensor and request inputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vs_meta  <= 1'b0;
            vs_s     <= 1'b0;
            ped_meta <= 1'b0;
            ped_s    <= 1'b0;
        end else begin
            vs_meta  <= bus.i_Vs;
            vs_s     <= vs_meta;
            ped_meta <= bus.i_ped_req;
            ped_s    <= ped_meta;
        end
    end

    // Prescaler counts 0..TICK_DIV-1. The tick is its terminal count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Gating with reset keeps the strobe low while reset is held, even when
    // TICK_DIV=1 makes the terminal count equal to the reset count.
    assign tick = (div_cnt == DIV_LAST) && !i_reset;

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= MG;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Timed exits fire on the tick where the timer reaches
    // D-1, so each state lasts exactly D ticks. Unused codes recover to MG at once.
    always_comb begin
        state_nxt = state;
        case (state)
            MG: begin
                if (tick && (timer >= LONG_LAST) && (vs_s || ped_pending)) begin
                    state_nxt = MY;
                end
            end
            MY: begin
                if (tick && (timer == SHORT_LAST)) begin
                    state_nxt = AR1;
                end
            end
            AR1: begin
                if (tick && (timer == ALLRED_LAST)) begin
                    state_nxt = SG;
                end
            end
            SG: begin
                if (tick && ((timer == LONG_LAST) ||
                             ((timer >= SHORT_LAST) && !vs_s))) begin
                    state_nxt = SY;
                end
            end
            SY: begin
                if (tick && (timer == SHORT_LAST)) begin
                    state_nxt = AR2;
                end
            end
            AR2: begin
                if (tick && (timer == ALLRED_LAST)) begin
                    state_nxt = MG;
                end
            end
            default: begin
                state_nxt = MG;
            end
        endcase
    end

    assign advance = (state_nxt != state);

    // Dwell timer clears on every state change and otherwise counts ticks.
    // It saturates so that an indefinitely held MG never wraps below the
    // green threshold.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer <= '0;
        end else if (advance) begin
            timer <= '0;
        end else if (tick && (timer != TIMER_MAX)) begin
            timer <= timer + 1'b1;
        end
    end

    // Pedestrian request latch. A request is remembered in any state except
    // SG, and it is consumed when SG is entered. A request that arrives on the
    // AR1->SG edge wins and stays pending for the next cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ped_pending <= 1'b0;
        end else if (ped_s && (state != SG)) begin
            ped_pending <= 1'b1;
        end else if ((state == AR1) && (state_nxt == SG)) begin
            ped_pending <= 1'b0;
        end
    end

    // Lamp decode from the state register alone. Unused codes show red both ways.
    always_comb begin
        bus.o_Main_red    = 1'b1;
        bus.o_Main_yellow = 1'b0;
        bus.o_Main_green  = 1'b0;
        bus.o_Side_red    = 1'b1;
        bus.o_Side_yellow = 1'b0;
        bus.o_Side_green  = 1'b0;
        bus.o_walk        = 1'b0;
        case (state)
            MG: begin
                bus.o_Main_red   = 1'b0;
                bus.o_Main_green = 1'b1;
            end
            MY: begin
                bus.o_Main_red    = 1'b0;
                bus.o_Main_yellow = 1'b1;
            end
            SG: begin
                bus.o_Side_red   = 1'b0;
                bus.o_Side_green = 1'b1;
                bus.o_walk       = 1'b1;
            end
            SY: begin
                bus.o_Side_red    = 1'b0;
                bus.o_Side_yellow = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.o_state = state;
    assign bus.o_tick  = tick;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Testbench for traffic_light_ctrl_param. A phase/dwell reference model in
// whole ticks predicts every output on every cycle. Directed scenarios add
// dwell-time, latency and reset checks.
module tb_traffic_light_ctrl_param;

  localparam int TD = 4;
  localparam int TWP = 4;
  localparam int LT = 8;
  localparam int ST = 3;
  localparam int AT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_light_ctrl_param_if bus ();

  traffic_light_ctrl_param #(
    .TICK_DIV(TD), .TW(TWP), .LONG_TICKS(LT), .SHORT_TICKS(ST), .ALLRED_TICKS(AT)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  // Observed vector: {state, main r/y/g, side r/y/g, walk, tick}.
  logic [10:0] obs_vec;
  assign obs_vec = {bus.o_state, bus.o_Main_red, bus.o_Main_yellow, bus.o_Main_green,
                    bus.o_Side_red, bus.o_Side_yellow, bus.o_Side_green,
                    bus.o_walk, bus.o_tick};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  // The phase index uses the published state codes. m_ticks counts the whole
  // ticks already spent in the phase. The model does not saturate this count.
  int m_div, m_phase, m_ticks;
  bit m_ped;
  bit vs_line[2];
  bit ped_line[2];

  function automatic logic [6:0] lamp_pattern(input int ph);
    // {main r,y,g, side r,y,g, walk}
    case (ph)
      0: return 7'b001_100_0;
      1: return 7'b010_100_0;
      3: return 7'b100_001_1;
      4: return 7'b100_010_0;
      default: return 7'b100_100_0;
    endcase
  endfunction

  function automatic logic [10:0] expected_vec();
    logic t;
    t = (m_div == TD - 1) && !rst;
    return {3'(m_phase), lamp_pattern(m_phase), t};
  endfunction

  task automatic model_reset();
    m_div = 0; m_phase = 0; m_ticks = 0; m_ped = 0;
    vs_line[0] = 0; vs_line[1] = 0; ped_line[0] = 0; ped_line[1] = 0;
  endtask

  task automatic model_edge(input bit vs_in, input bit ped_in);
    bit vs_s, ped_s, tk;
    int nxt, elapsed;
    vs_s = vs_line[1];
    ped_s = ped_line[1];
    tk = (m_div == TD - 1);
    nxt = m_phase;
    elapsed = m_ticks + 1;
    if (tk) begin
      case (m_phase)
        0: if (elapsed >= LT && (vs_s || m_ped)) nxt = 1;
        1: if (elapsed == ST) nxt = 2;
        2: if (elapsed == AT) nxt = 3;
        3: if (elapsed == LT || (elapsed >= ST && !vs_s)) nxt = 4;
        4: if (elapsed == ST) nxt = 5;
        5: if (elapsed == AT) nxt = 0;
        default: nxt = 0;
      endcase
    end
    if (ped_s && m_phase != 3) m_ped = 1;
    else if (m_phase == 2 && nxt == 3) m_ped = 0;
    if (nxt != m_phase) m_ticks = 0;
    else if (tk) m_ticks++;
    m_phase = nxt;
    m_div = (m_div + 1) % TD;
    vs_line[1] = vs_line[0]; vs_line[0] = vs_in;
    ped_line[1] = ped_line[0]; ped_line[0] = ped_in;
  endtask

  // ---------------- observed dwell monitor ----------------
  int mon_state, mon_ticks, walk_ticks, tick_count, last_tick_cyc, bad_gaps, cyc;
  int dwell_q[$];
  int dstate_q[$];

  task automatic monitor_clear();
    mon_state = 0; mon_ticks = 0; walk_ticks = 0;
    dwell_q.delete(); dstate_q.delete();
  endtask

  task automatic monitor_sample();
    cyc++;
    if (int'(bus.o_state) != mon_state) begin
      dstate_q.push_back(mon_state);
      dwell_q.push_back(mon_ticks);
      mon_state = int'(bus.o_state);
      mon_ticks = 0;
    end
    if (bus.o_tick) begin
      mon_ticks++;
      tick_count++;
      if (last_tick_cyc >= 0 && cyc - last_tick_cyc != TD) bad_gaps++;
      last_tick_cyc = cyc;
      if (bus.o_walk) walk_ticks++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Starts and ends at a falling edge.
  task automatic step(input bit vs, input bit ped);
    bus.i_Vs = vs;
    bus.i_ped_req = ped;
    @(posedge clk);
    if (!rst) model_edge(vs, ped);
    exp_q.push_back(expected_vec());
    @(negedge clk);
    check("cycle_outputs", 32'(obs_vec), 32'(exp_q.pop_front()));
    monitor_sample();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("reset_async", 32'(obs_vec), 32'({3'd0, 7'b001_100_0, 1'b0}));
    model_reset();
    monitor_clear();
    step(0, 0);
    step(0, 0);
    rst = 1'b0;
    tick_count = 0; last_tick_cyc = -1; bad_gaps = 0; cyc = 0;
  endtask

  task automatic run_until_state(input bit vs, input int target, input int bound, input string tag);
    bit reached;
    reached = 0;
    for (int i = 0; i < bound && !reached; i++) begin
      step(vs, 0);
      if (int'(bus.o_state) == target) reached = 1;
    end
    check(tag, 32'(reached), 32'd1);
  endtask

  task automatic check_dwells(input string tag, input int n, input int exp_d[12]);
    check({tag, "_count"}, 32'(dwell_q.size() >= n), 32'd1);
    for (int i = 0; i < n && i < dwell_q.size(); i++) begin
      check({tag, "_state"}, 32'(dstate_q[i]), 32'(i % 6));
      check({tag, "_ticks"}, 32'(dwell_q[i]), 32'(exp_d[i]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int full_d[12];
    int ped_d[12];
    int lat;
    bit found, vs_r, done_my;
    bus.i_Vs = 0;
    bus.i_ped_req = 0;
    tick_count = 0; last_tick_cyc = -1; bad_gaps = 0; cyc = 0;
    full_d = '{LT, ST, AT, LT, ST, AT, LT, ST, AT, LT, ST, AT};
    ped_d = '{LT, ST, AT, ST, ST, AT, 0, 0, 0, 0, 0, 0};

    @(negedge clk);
    apply_reset();

    // Idle with no demand: MG held, tick every TD cycles.
    repeat (400) step(0, 0);
    check("idle_state", 32'(bus.o_state), 32'd0);
    check("idle_tick_count", 32'(tick_count), 32'd100);
    check("idle_tick_gaps", 32'(bad_gaps), 32'd0);
    check("idle_no_transitions", 32'(dwell_q.size()), 32'd0);

    // Timer saturated in MG. A vehicle must still trigger MY promptly.
    lat = 0; done_my = 0;
    for (int i = 0; i < 3 * TD && !done_my; i++) begin
      step(1, 0);
      lat++;
      if (bus.o_state == 3'd1) done_my = 1;
    end
    check("sat_reached_my", 32'(done_my), 32'd1);
    check("sat_latency_ok", 32'(lat >= 1 && lat <= TD + 2), 32'd1);

    // Constant vehicle demand: two full rounds of fixed dwell times.
    apply_reset();
    repeat (2 * (2 * LT + 2 * ST + 2 * AT) * TD + 12) step(1, 0);
    check_dwells("full_cycle", 12, full_d);

    // Vehicle leaves once SG starts: SG ends after the minimum side green.
    apply_reset();
    run_until_state(1, 3, 200, "reach_sg_early");
    repeat (60) step(0, 0);
    found = 0;
    for (int i = 0; i < dstate_q.size(); i++) begin
      if (dstate_q[i] == 3 && !found) begin
        found = 1;
        check("sg_early_ticks", 32'(dwell_q[i]), 32'(ST));
        check("sg_early_next", 32'((i + 1 < dstate_q.size()) ? dstate_q[i + 1] : mon_state), 32'd4);
      end
    end
    check("sg_early_found", 32'(found), 32'd1);

    // Single pedestrian pulse in MG with no vehicle.
    apply_reset();
    repeat (5) step(0, 0);
    step(0, 1);
    repeat (150) step(0, 0);
    check_dwells("ped_cycle", 6, ped_d);
    check("ped_walk_ticks", 32'(walk_ticks), 32'(ST));
    check("ped_then_mg_held", 32'(dstate_q.size()), 32'd6);
    check("ped_final_state", 32'(bus.o_state), 32'd0);

    // Reset asserted in the middle of SG.
    apply_reset();
    run_until_state(1, 3, 200, "reach_sg_for_reset");
    step(1, 0);
    apply_reset();
    check("post_reset_walk", 32'(bus.o_walk), 32'd0);

    // Randomised demand with occasional resets.
    vs_r = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) vs_r = ~vs_r;
      if ($urandom_range(0, 499) == 0) apply_reset();
      else step(vs_r, $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl_param.md
TRAFFIC_LIGHT_CTRL_PARAM -- requirements
Module: traffic_light_ctrl_param

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50, clock cycles per timing tick (>=1).
REQ-002 SHALL have parameter TW, default 8, tick-timer width in bits.
REQ-003 SHALL have parameter LONG_TICKS, default 20, green duration in ticks (1..2^TW-1).
REQ-004 SHALL have parameter SHORT_TICKS, default 4, yellow duration and minimum side-green in ticks (1..LONG_TICKS).
REQ-005 SHALL have parameter ALLRED_TICKS, default 2, all-red clearance duration in ticks (1..2^TW-1).
REQ-006 SHALL have ports: i_clk  input  1  single system clock, rising edge.
REQ-007 i_reset  input  1  asynchronous, active-high reset.
REQ-008 i_Vs  input  1  side-road vehicle sensor, asynchronous to i_clk.
REQ-009 i_ped_req  input  1  pedestrian request, asynchronous, pulse >=1 cycle.
REQ-010 o_Main_red, o_Main_yellow, o_Main_green  output  1 each  main-road lamps.
REQ-011 o_Side_red, o_Side_yellow, o_Side_green  output  1 each  side-road lamps.
REQ-012 o_walk  output  1  pedestrian walk lamp.
REQ-013 o_state  output  3  current state code.
REQ-014 o_tick  output  1  one-cycle timing-tick strobe.

Function
REQ-015 SHALL pass i_Vs and i_ped_req through two-flop synchronisers (vs_s, ped_s); 2-cycle latency.
REQ-016 SHALL run prescaler 0..TICK_DIV-1 on i_clk; o_tick=1 for exactly the cycle where count==TICK_DIV-1; TICK_DIV=1 gives o_tick=1 every cycle.
REQ-017 No derived or gated clock; all state advances via o_tick as enable.
REQ-018 States/codes: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5; codes 6,7 SHALL go to MG on the next clock.
REQ-019 Tick timer: on each tick, if no transition, timer increments, saturating at 2^TW-1; on transition, timer=0.
REQ-020 Transitions evaluated only on tick cycles; "done(D)" means timer==D-1 on that tick, so state lasts exactly D ticks.
REQ-021 MG->MY when timer>=LONG_TICKS-1 and (vs_s or ped_pending); no demand -> MG held indefinitely.
REQ-022 MY->AR1 on done(SHORT_TICKS); AR1->SG on done(ALLRED_TICKS).
REQ-023 SG->SY on done(LONG_TICKS), or early when timer>=SHORT_TICKS-1 and vs_s==0, both evaluated on the same tick.
REQ-024 SY->AR2 on done(SHORT_TICKS); AR2->MG on done(ALLRED_TICKS).
REQ-025 ped_pending set by ped_s==1 in any state except SG; cleared on entry to SG; set has priority only outside SG.
REQ-026 Lamp decode from state register only (no input path): MG main green/side red; MY main yellow/side red; AR1, AR2 both red; SG main red/side green; SY main red/side yellow.
REQ-027 o_walk=1 only in SG; exactly one lamp per road SHALL be lit in every state.
REQ-028 o_state equals state register; lamps change in the cycle after the transition edge.

Reset
REQ-029 i_reset=1 SHALL asynchronously force: state=MG, timer=0, prescaler=0, ped_pending=0, synchronisers=0.
REQ-030 During and after reset: o_Main_green=1, o_Side_red=1, others 0, o_walk=0, o_state=0, o_tick=0.
REQ-031 Reset release: first tick occurs TICK_DIV cycles after the first clock edge with i_reset=0.

Verification (TICK_DIV=4, LONG=8, SHORT=3, ALLRED=2)
REQ-032 Reset pulse mid-SG -> same cycle o_Main_green=1, o_Side_red=1, o_walk=0, o_state=0, without clock edge.
REQ-033 i_Vs=0, i_ped_req=0 for 400 cycles -> o_state stays 0, o_tick period 4 cycles.
REQ-034 i_Vs=1 constant from reset -> state dwell in ticks MG 8, MY 3, AR1 2, SG 8, SY 3, AR2 2, then MG; repeats.
REQ-035 i_Vs=1 until SG entered, then 0 -> SG lasts 3 ticks, then SY.
REQ-036 Single-cycle i_ped_req in MG, i_Vs=0 -> MY at MG tick 8; o_walk=1 for 3 ticks of SG; ped_pending=0 afterwards; MG then held.
REQ-037 Force timer saturation (MG, no demand, TW=4, 40 ticks), then i_Vs=1 -> MY within 1 tick + 2 cycles sync; no timer wrap.
